transient_monitor: RTL and testbench
====================================

TRANSIENT_MONITOR -- requirements
Module: transient_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent monitored input channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-channel hold-off counter.
REQ-003 SHALL have parameter SCALE, default 10000: counter cycles per delay_sel step; SCALE*15 SHALL fit in CNT_W bits (elaboration check).
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port sig_in, input, CHANNELS: monitored signals, already synchronous to clk.
REQ-007 SHALL have port delay_sel, input, 4: hold-off length in SCALE units, shared by all channels.
REQ-008 SHALL have port mode, input, 2: 00 any edge, 01 rising only, 10 falling only, 11 any edge with retrigger.
REQ-009 SHALL have port clr, input, 1: synchronous clear of event_count.
REQ-010 SHALL have port busy, output, CHANNELS: channel is in its hold-off window.
REQ-011 SHALL have port stable_out, output, CHANNELS: last settled value per channel.
REQ-012 SHALL have port any_busy, output, 1: OR of busy.
REQ-013 SHALL have port event_count, output, 8: saturating count of hold-off starts.

Function
REQ-014 SHALL register sig_in every cycle into s_q; per-channel change chg = sig_in XOR s_q; rise = chg AND sig_in; fall = chg AND NOT sig_in.
REQ-015 SHALL run one FSM per channel with states IDLE and HOLD; busy = (state == HOLD), registered.
REQ-016 IDLE: on a qualifying edge (per mode), SHALL load counter with SCALE*delay_sel (computed at CNT_W bits) and enter HOLD next cycle; otherwise remain IDLE.
REQ-017 HOLD: if counter == 0, SHALL return to IDLE and load stable_out[i] with s_q[i]; else SHALL decrement counter by 1.
REQ-018 With sig_in changing at edge N, busy SHALL be high from cycle N+1 for exactly SCALE*delay_sel+1 cycles.
REQ-019 delay_sel = 0 SHALL give a one-cycle HOLD (no skip, no wrap).
REQ-020 Modes 00/01/10: edges during HOLD SHALL be ignored; the counter SHALL never underflow.
REQ-021 Mode 11: any edge during HOLD SHALL reload counter with SCALE*delay_sel, including at counter == 0 (reload wins over exit).
REQ-022 delay_sel and mode SHALL be sampled only at load/reload; changes mid-HOLD SHALL not affect the running count.
REQ-023 event_count SHALL increment by 1 in any cycle where at least one channel enters HOLD from IDLE (reloads excluded), saturating at 255.
REQ-024 clr SHALL zero event_count next cycle; clr and increment in the same cycle SHALL yield 0.
REQ-025 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each start their own HOLD.

Reset
REQ-026 reset SHALL force all FSMs to IDLE, all counters to 0, s_q to 0, stable_out to 0, busy to 0, any_busy to 0, event_count to 0.
REQ-027 reset asserted mid-HOLD SHALL abort the window with no stable_out update; the first post-reset cycle SHALL compare against s_q = 0.

Structure
REQ-028 Shared package transient_pkg SHALL hold the mode encodings (MODE_ANY, MODE_RISE, MODE_FALL, MODE_RETRIG) and the channel state enum (ST_IDLE, ST_HOLD).
REQ-029 Per-channel FSM plus counter SHALL be sub-module transient_channel, instantiated CHANNELS times; event_count and any_busy SHALL live in the top level.

Verification (SCALE = 4, CHANNELS = 4 unless stated)
REQ-030 Reset, then sig_in 0000->0001 with delay_sel = 2, mode 00 -> busy[0] high for exactly 9 cycles, stable_out = 0001 after, event_count = 1.
REQ-031 Mode 01, ch1 falls then rises -> only the rise starts HOLD; event_count = 1.
REQ-032 Mode 00 vs 11, ch2 toggles every 3 cycles for 12 cycles, delay_sel = 1 -> mode 00 busy ends 5 cycles after the first edge; mode 11 ends 5 cycles after the last edge.
REQ-033 delay_sel = 0, single edge -> busy high exactly 1 cycle.
REQ-034 300 edges on ch0, delay_sel = 0 -> event_count saturates at 255; clr held coincident with an edge -> 0.
REQ-035 reset pulse mid-HOLD on ch3 -> busy = 0 and stable_out = 0 the following cycle.

Source files
------------

// File: rtl/transient_pkg.sv
// Shared types for the transient monitor: edge-mode encodings,
// per-channel state enum and the edge qualification helper.
package transient_pkg;

  typedef enum logic [1:0] {
    MODE_ANY    = 2'b00,
    MODE_RISE   = 2'b01,
    MODE_FALL   = 2'b10,
    MODE_RETRIG = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ch_state_e;

  function automatic logic edge_qual(
    input mode_e m,
    input logic  rise,
    input logic  fall
  );
    logic q;
    case (m)
      MODE_RISE: q = rise;
      MODE_FALL: q = fall;
      default:   q = rise | fall;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/transient_channel.sv
// One monitored channel: edge detect, IDLE/HOLD FSM, hold-off counter.
// Ports: clk, reset, sig_in, delay_sel, mode in; busy, stable_out, start out.
module transient_channel
  import transient_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SCALE = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  input  logic [3:0] delay_sel,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       stable_out,
  output logic       start
);

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  mode_e            mode_q, mode_q_n;
  logic             s_q;
  logic             stable_n;
  logic             chg, rise, fall;
  logic [CNT_W-1:0] load_val;

  assign chg  = sig_in ^ s_q;
  assign rise = chg & sig_in;
  assign fall = chg & ~sig_in;

  assign load_val = CNT_W'(SCALE) * CNT_W'(delay_sel);

  assign busy = (state == ST_HOLD);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mode_q_n = mode_q;
    stable_n = stable_out;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (edge_qual(mode_e'(mode), rise, fall)) begin
          state_n  = ST_HOLD;
          cnt_n    = load_val;
          mode_q_n = mode_e'(mode);
          start    = 1'b1;
        end
      end
      ST_HOLD: begin
        // Retrigger has priority over the exit at count zero.
        if (mode_q == MODE_RETRIG && chg) begin
          cnt_n    = load_val;
          mode_q_n = mode_e'(mode);
        end else if (cnt == '0) begin
          state_n  = ST_IDLE;
          stable_n = s_q;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode_q     <= MODE_ANY;
      s_q        <= 1'b0;
      stable_out <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mode_q     <= mode_q_n;
      s_q        <= sig_in;
      stable_out <= stable_n;
    end
  end

endmodule

// File: rtl/transient_monitor.sv
// Multi-channel transient monitor with per-channel hold-off windows.
// Ports: clk, reset, sig_in, delay_sel, mode, clr in; busy, stable_out, any_busy, event_count out.
module transient_monitor
  import transient_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16,
  parameter int SCALE    = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic [3:0]          delay_sel,
  input  logic [1:0]          mode,
  input  logic                clr,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] stable_out,
  output logic                any_busy,
  output logic [7:0]          event_count
);

  localparam longint unsigned MAX_CNT =
    (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned MAX_LOAD =
    64'(SCALE) * 64'd15;

  if (MAX_LOAD > MAX_CNT) begin : g_bad_scale
    $error("SCALE*15 does not fit in CNT_W bits");
  end

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("CHANNELS must be 1..16");
  end

  logic [CHANNELS-1:0] start;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    transient_channel #(
      .CNT_W (CNT_W),
      .SCALE (SCALE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in[i]),
      .delay_sel  (delay_sel),
      .mode       (mode),
      .busy       (busy[i]),
      .stable_out (stable_out[i]),
      .start      (start[i])
    );
  end

  assign any_busy = |busy;

  // clr dominates a coincident increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_count <= 8'd0;
    end else if (clr) begin
      event_count <= 8'd0;
    end else if (|start && event_count != 8'hFF) begin
      event_count <= event_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_transient_monitor.sv
// Scoreboard bench for transient_monitor (SCALE=4, CHANNELS=4).
// Stimulus queues timed expectations; a negedge monitor checks them.
module tb_transient_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig;
  logic [3:0] delay_sel;
  logic [1:0] mode;
  logic       clr;
  logic [3:0] busy;
  logic [3:0] stable_out;
  logic       any_busy;
  logic [7:0] event_count;

  localparam int K_BUSY = 0;
  localparam int K_STAB = 1;
  localparam int K_ANY  = 2;
  localparam int K_EV   = 3;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic        done = 1'b0;
  int          drain = 0;
  logic [7:0]  act;

  transient_monitor #(
    .CHANNELS (4),
    .CNT_W    (16),
    .SCALE    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig),
    .delay_sel   (delay_sel),
    .mode        (mode),
    .clr         (clr),
    .busy        (busy),
    .stable_out  (stable_out),
    .any_busy    (any_busy),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(
    input int         d,
    input int         kind,
    input logic [7:0] v,
    input string      nm
  );
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_BUSY:  act = {4'b0, busy};
          K_STAB:  act = {4'b0, stable_out};
          K_ANY:   act = {7'b0, any_busy};
          default: act = event_count;
        endcase
        vectors++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d: got %0h want %0h",
                   sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      drain++;
      if (sb.size() == 0 || drain > 100) begin
        foreach (sb[j]) begin
          errors++;
          $display("FAIL %s never checked: got - want %0h",
                   sb[j].name, sb[j].val);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    sig       = 4'b0000;
    delay_sel = 4'd0;
    mode      = 2'b00;
    clr       = 1'b0;
    tick(2);
    expect_at(0, K_BUSY, 8'h0, "rst_busy");
    expect_at(0, K_STAB, 8'h0, "rst_stable");
    expect_at(0, K_ANY,  8'h0, "rst_any");
    expect_at(0, K_EV,   8'h0, "rst_ev");
    reset = 1'b0;
    tick(2);

    // basic window: delay 2 -> 9 cycles busy
    delay_sel = 4'd2;
    sig = 4'b0001;
    expect_at(0, K_BUSY, 8'h0, "t1_pre");
    for (int d = 1; d <= 9; d++)
      expect_at(d, K_BUSY, 8'h1, "t1_busy");
    expect_at(1,  K_ANY,  8'h1, "t1_any");
    expect_at(1,  K_EV,   8'h1, "t1_ev");
    expect_at(10, K_BUSY, 8'h0, "t1_end");
    expect_at(10, K_STAB, 8'h1, "t1_stable");
    expect_at(10, K_EV,   8'h1, "t1_ev_end");
    tick(12);

    // rise-only: fall ignored, rise starts
    mode = 2'b10;
    sig = 4'b0011;
    expect_at(1, K_BUSY, 8'h0, "t2_ign_rise");
    expect_at(2, K_BUSY, 8'h0, "t2_ign_rise2");
    tick(2);
    clr = 1'b1;
    expect_at(1, K_EV, 8'h0, "t2_clr");
    tick(1);
    clr = 1'b0;
    mode = 2'b01;
    sig = 4'b0001;
    expect_at(1, K_BUSY, 8'h0, "t2_fall");
    expect_at(2, K_BUSY, 8'h0, "t2_fall2");
    tick(3);
    sig = 4'b0011;
    expect_at(1,  K_BUSY, 8'h2, "t2_rise");
    expect_at(9,  K_BUSY, 8'h2, "t2_last");
    expect_at(10, K_BUSY, 8'h0, "t2_end");
    expect_at(1,  K_EV,   8'h1, "t2_ev");
    expect_at(10, K_EV,   8'h1, "t2_ev_end");
    expect_at(10, K_STAB, 8'h3, "t2_stable");
    expect_at(10, K_ANY,  8'h0, "t2_any");
    tick(11);

    // mode 00, ch2 toggling every 3 cycles, delay 1
    delay_sel = 4'd1;
    mode = 2'b00;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    sig = 4'b0111;
    expect_at(1,  K_BUSY, 8'h4, "t3a_b1");
    expect_at(5,  K_BUSY, 8'h4, "t3a_b5");
    expect_at(6,  K_BUSY, 8'h0, "t3a_end");
    expect_at(7,  K_BUSY, 8'h4, "t3a_again");
    expect_at(11, K_BUSY, 8'h4, "t3a_b11");
    expect_at(12, K_BUSY, 8'h0, "t3a_end2");
    expect_at(1,  K_EV,   8'h1, "t3a_ev1");
    expect_at(7,  K_EV,   8'h2, "t3a_ev2");
    expect_at(12, K_STAB, 8'h3, "t3a_stable");
    tick(3);
    sig = 4'b0011;
    tick(3);
    sig = 4'b0111;
    tick(3);
    sig = 4'b0011;
    tick(5);

    // mode 11, same pattern: window follows last edge
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    mode = 2'b11;
    sig = 4'b0111;
    expect_at(1,  K_BUSY, 8'h4, "t3b_b1");
    expect_at(6,  K_BUSY, 8'h4, "t3b_b6");
    expect_at(14, K_BUSY, 8'h4, "t3b_b14");
    expect_at(15, K_BUSY, 8'h0, "t3b_end");
    expect_at(1,  K_EV,   8'h1, "t3b_ev");
    expect_at(15, K_EV,   8'h1, "t3b_ev_end");
    expect_at(15, K_STAB, 8'h3, "t3b_stable");
    tick(3);
    sig = 4'b0011;
    tick(3);
    sig = 4'b0111;
    tick(3);
    sig = 4'b0011;
    tick(7);

    // retrigger at count zero wins over exit
    delay_sel = 4'd0;
    sig = 4'b1011;
    expect_at(1, K_BUSY, 8'h8, "t3c_b1");
    expect_at(2, K_BUSY, 8'h8, "t3c_b2");
    expect_at(3, K_BUSY, 8'h8, "t3c_b3");
    expect_at(4, K_BUSY, 8'h0, "t3c_end");
    expect_at(4, K_STAB, 8'hB, "t3c_stable");
    expect_at(4, K_EV,   8'h2, "t3c_ev");
    tick(1);
    sig = 4'b0011;
    tick(1);
    sig = 4'b1011;
    tick(4);

    // delay 0: one-cycle hold
    mode = 2'b00;
    sig = 4'b1010;
    expect_at(1, K_BUSY, 8'h1, "t4_b1");
    expect_at(2, K_BUSY, 8'h0, "t4_end");
    expect_at(2, K_STAB, 8'hA, "t4_stable");
    tick(3);

    // saturation over 300 starts
    clr = 1'b1;
    expect_at(1, K_EV, 8'h0, "t5_clr");
    tick(1);
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sig[0] = ~sig[0];
      expect_at(1, K_EV, (i + 1 > 255) ? 8'd255 : 8'(i + 1), "t5_sat");
      tick(2);
    end
    sig = 4'b1011;
    clr = 1'b1;
    expect_at(1, K_EV,   8'h0, "t5_clr_edge");
    expect_at(1, K_BUSY, 8'h1, "t5_clr_busy");
    tick(1);
    clr = 1'b0;
    tick(3);

    // reset mid-hold on ch3
    sig = 4'b0111;
    tick(4);
    delay_sel = 4'd2;
    sig = 4'b1111;
    expect_at(1, K_BUSY, 8'h8, "t6_busy");
    expect_at(1, K_STAB, 8'h7, "t6_stable");
    tick(3);
    reset = 1'b1;
    expect_at(1, K_BUSY, 8'h0, "t6_rbusy");
    expect_at(1, K_STAB, 8'h0, "t6_rstable");
    expect_at(1, K_EV,   8'h0, "t6_rev");
    expect_at(1, K_ANY,  8'h0, "t6_rany");
    tick(1);
    reset = 1'b0;
    expect_at(1, K_BUSY, 8'hF, "t6_post_busy");
    expect_at(1, K_EV,   8'h1, "t6_post_ev");
    expect_at(1, K_ANY,  8'h1, "t6_post_any");
    tick(2);
    done = 1'b1;
  end

endmodule
